// File: rtl/demux_dispatch.sv
// rtl/demux_dispatch.sv - round-robin single-word dispatcher feeding demux
//
// Purpose: holds one upstream word and steers it to one of N = 2**SEL_W
// downstream channels. It drives demux.sel and the one-hot channel valids,
// and honours per-channel backpressure.
// Optional feature: define DISPATCH_SKIP_EN for work-conserving selection,
// where a stalled channel is skipped. When it is undefined the dispatcher
// uses strict round-robin order.
//
// Ports:
//   clk        in  1       rising-edge clock
//   rst_n      in  1       asynchronous active-low reset
//   in_valid   in  1       upstream word valid
//   in_data    in  DATA_W  upstream word
//   in_ready   out 1       word accepted on this edge if in_valid
//   ch_ready   in  N       per-channel ready from consumers
//   sel        out SEL_W   channel index for demux.sel
//   out_valid  out N       one-hot channel valid
//   out_data   out DATA_W  held word, broadcast to all channels
//   xfer_cnt   out CNT_W   completed dispatches, wraps silently
module demux_dispatch #(
  parameter int SEL_W  = 2,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  input  logic [(2**SEL_W)-1:0] ch_ready,
  output logic [SEL_W-1:0]      sel,
  output logic [(2**SEL_W)-1:0] out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [CNT_W-1:0]      xfer_cnt
);

  localparam int N = 2**SEL_W;

  // The state is exactly buf_valid: EMPTY means no word is held.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   buf_data;
  logic [SEL_W-1:0]    ptr;
  logic [SEL_W-1:0]    target;
  logic                buf_valid;
  logic                fire;
  logic                load;

  assign buf_valid = (state_q == FULL);

`ifdef DISPATCH_SKIP_EN
  // Search the channels in rotating order, starting at ptr. The first ready
  // one wins. If no channel is ready, the target stays at ptr so that sel
  // is stable while everything is stalled.
  logic [SEL_W-1:0] idx;
  logic             found;
  always_comb begin
    target = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int i = 0; i < N; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && ch_ready[idx]) begin
        target = idx;
        found  = 1'b1;
      end
    end
  end
`else
  assign target = ptr;
`endif

  assign fire      = buf_valid & ch_ready[target];
  // The consumer's ready propagates combinationally to in_ready. This path
  // lets a word be accepted and another dispatched on the same edge.
  assign in_ready  = rst_n & (~buf_valid | fire);
  assign sel       = buf_valid ? target : ptr;
  assign out_valid = buf_valid ? (N'(1) << sel) : '0;
  assign out_data  = buf_data;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (fire) begin
          if (in_valid) begin
            load = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      buf_data <= '0;
      ptr      <= '0;
      xfer_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        buf_data <= in_data;
      end
      if (fire) begin
        ptr      <= target + SEL_W'(1);
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
    end
  end

endmodule
